// File: rtl/imply_stack_if.sv
// imply_stack_if: push, backtrack and pop bundle between the solver and imply_stack.
// peak_count is present only when IMPLY_STACK_PEAK_EN is defined.
interface imply_stack_if #(
    parameter int VAR_BITS = 9,
    parameter int CNT_BITS = 10
);
    logic                push_valid;
    logic [VAR_BITS-1:0] push_var;
    logic                push_val;
    logic                push_decision;
    logic                push_ready;
    logic                bt_start;
    logic                pop_valid;
    logic [VAR_BITS-1:0] pop_var;
    logic                pop_val;
    logic                pop_decision;
    logic                bt_busy;
    logic                bt_done;
    logic                bt_unsat;
    logic [CNT_BITS-1:0] count;
    logic [CNT_BITS-1:0] level;
    logic                full;
    logic                empty;
    logic                overflow;
`ifdef IMPLY_STACK_PEAK_EN
    logic [CNT_BITS-1:0] peak_count;
    modport master (
        output push_valid, push_var, push_val, push_decision, bt_start,
        input  push_ready, pop_valid, pop_var, pop_val, pop_decision,
        input  bt_busy, bt_done, bt_unsat, count, level, full, empty, overflow, peak_count
    );
    modport slave (
        input  push_valid, push_var, push_val, push_decision, bt_start,
        output push_ready, pop_valid, pop_var, pop_val, pop_decision,
        output bt_busy, bt_done, bt_unsat, count, level, full, empty, overflow, peak_count
    );
`else
    modport master (
        output push_valid, push_var, push_val, push_decision, bt_start,
        input  push_ready, pop_valid, pop_var, pop_val, pop_decision,
        input  bt_busy, bt_done, bt_unsat, count, level, full, empty, overflow
    );
    modport slave (
        input  push_valid, push_var, push_val, push_decision, bt_start,
        output push_ready, pop_valid, pop_var, pop_val, pop_decision,
        output bt_busy, bt_done, bt_unsat, count, level, full, empty, overflow
    );
`endif
endinterface

// File: rtl/imply_stack.sv
// imply_stack: LIFO assignment trail that pops back to the most recent decision on request.
// Defining IMPLY_STACK_PEAK_EN adds a peak_count high-water mark output.
module imply_stack #(
    parameter int VAR_BITS = 9,
    parameter int DEPTH    = 512,
    parameter int CNT_BITS = 10
) (
    input logic          clock,
    input logic          reset,
    imply_stack_if.slave bus
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, POP, DONE} state_t;

    typedef struct packed {
        logic [VAR_BITS-1:0] idx;
        logic                val;
        logic                decision;
    } entry_t;

    state_t               state, state_next;
    entry_t               mem [DEPTH];
    entry_t               top;
    entry_t               pop_entry;
    logic [CNT_BITS-1:0]  count, level;
    logic [ADDR_BITS-1:0] wr_addr, rd_addr;
    logic                 full, empty, push_ready, push_go, pop_go, last_pop;
    logic                 pop_valid, bt_unsat, overflow;

    assign full     = count == CNT_BITS'(DEPTH);
    assign empty    = count == '0;
    assign wr_addr  = ADDR_BITS'(count);
    assign rd_addr  = ADDR_BITS'(count - CNT_BITS'(1));
    assign top      = mem[rd_addr];
    assign push_go  = bus.push_valid && push_ready;
    assign pop_go   = state == POP && !empty;
    // The backtrack ends on the pop that removes a decision or drains the stack.
    assign last_pop = pop_go && (top.decision || count == CNT_BITS'(1));

    always_comb begin
        state_next = state;
        push_ready = 1'b0;
        case (state)
            IDLE: begin
                state_next = bus.bt_start ? POP : IDLE;
                push_ready = !full && !bus.bt_start;
            end
            POP:     state_next = (empty || last_pop) ? DONE : POP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            level     <= '0;
            pop_valid <= 1'b0;
            pop_entry <= '0;
            bt_unsat  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            pop_valid <= pop_go;
            if (pop_go)
                pop_entry <= top;
            if (push_go) begin
                count <= count + CNT_BITS'(1);
                level <= level + CNT_BITS'(bus.push_decision);
            end else if (pop_go) begin
                count <= count - CNT_BITS'(1);
                level <= level - CNT_BITS'(top.decision);
            end
            if (state == IDLE && bus.push_valid && full)
                overflow <= 1'b1;
            if (state == IDLE && bus.bt_start)
                bt_unsat <= 1'b0;
            else if (state == POP && (empty || last_pop))
                bt_unsat <= empty || !top.decision;
        end
    end

    always_ff @(posedge clock)
        if (push_go)
            mem[wr_addr] <= {bus.push_var, bus.push_val, bus.push_decision};

`ifdef IMPLY_STACK_PEAK_EN
    logic [CNT_BITS-1:0] peak;

    always_ff @(posedge clock) begin
        if (reset)
            peak <= '0;
        else if (push_go && count + CNT_BITS'(1) > peak)
            peak <= count + CNT_BITS'(1);
    end

    assign bus.peak_count = peak;
`endif

    assign bus.push_ready   = push_ready;
    assign bus.pop_valid    = pop_valid;
    assign bus.pop_var      = pop_entry.idx;
    assign bus.pop_val      = pop_entry.val;
    assign bus.pop_decision = pop_entry.decision;
    assign bus.bt_busy      = state != IDLE;
    assign bus.bt_done      = state == DONE;
    assign bus.bt_unsat     = bt_unsat;
    assign bus.count        = count;
    assign bus.level        = level;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.overflow     = overflow;
endmodule

// File: tb/tb_imply_stack.sv
// tb_imply_stack: random and directed stimulus for imply_stack, checked every cycle
// against a queue-based model of the trail plus literal expectations.
module tb_imply_stack;
    localparam int VB = 9, CB = 10, DEPTH = 512;

    typedef struct packed {
        logic [VB-1:0] v;
        logic          val;
        logic          dec;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    imply_stack_if #(.VAR_BITS(VB), .CNT_BITS(CB)) bus ();
    imply_stack #(.VAR_BITS(VB), .DEPTH(DEPTH), .CNT_BITS(CB)) dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    // Model: stk is the trail; a backtrack moves its victims into plist and
    // bt_j counts cycles since bt_start, so every output is a function of j.
    ent_t stk[$];
    ent_t plist[$];
    int   bt_j = -1, bt_d = 0, m_lvl = 0, m_peak = 0;
    bit   m_ovf = 1'b0, m_unsat = 1'b0, unsat_next = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin : mdl
        ent_t e;
        if (reset) begin
            stk.delete();
            plist.delete();
            bt_j = -1; m_lvl = 0; m_peak = 0; m_ovf = 1'b0; m_unsat = 1'b0;
        end else if (bt_j >= 0) begin
            bt_j++;
            if (bt_j == bt_d) m_unsat = unsat_next;
            else if (bt_j > bt_d) bt_j = -1;
        end else if (bus.bt_start) begin
            if (bus.push_valid && stk.size() == DEPTH) m_ovf = 1'b1;
            plist.delete();
            while (stk.size() > 0) begin
                e = stk.pop_back();
                plist.push_back(e);
                if (e.dec) break;
            end
            unsat_next = plist.size() == 0 || !plist[$].dec;
            if (plist.size() > 0 && plist[$].dec) m_lvl--;
            bt_d = plist.size() == 0 ? 1 : plist.size();
            bt_j = 0;
            m_unsat = 1'b0;
        end else if (bus.push_valid) begin
            if (stk.size() < DEPTH) begin
                e = {bus.push_var, bus.push_val, bus.push_decision};
                stk.push_back(e);
                m_lvl += int'(e.dec);
                if (stk.size() > m_peak) m_peak = stk.size();
            end else m_ovf = 1'b1;
        end
    end

    always @(negedge clock) if (chk_on) begin : cmp
        int k, j, ec, el;
        bit pv;
        k  = plist.size();
        j  = bt_j;
        ec = j < 0 ? stk.size() : stk.size() + k - (j < k ? j : k);
        el = m_lvl + ((j >= 0 && j < k && plist[k-1].dec) ? 1 : 0);
        pv = j >= 1 && j <= k;
        check("count", int'(bus.count), ec);
        check("level", int'(bus.level), el);
        check("empty", int'(bus.empty), int'(ec == 0));
        check("full", int'(bus.full), int'(ec == DEPTH));
        check("push_ready", int'(bus.push_ready), int'(j < 0 && ec < DEPTH && !bus.bt_start));
        check("bt_busy", int'(bus.bt_busy), int'(j >= 0));
        check("bt_done", int'(bus.bt_done), int'(j >= 0 && j == bt_d));
        check("bt_unsat", int'(bus.bt_unsat), int'(m_unsat));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("pop_valid", int'(bus.pop_valid), int'(pv));
        if (pv) begin
            check("pop_var", int'(bus.pop_var), int'(plist[j-1].v));
            check("pop_val", int'(bus.pop_val), int'(plist[j-1].val));
            check("pop_decision", int'(bus.pop_decision), int'(plist[j-1].dec));
        end
`ifdef IMPLY_STACK_PEAK_EN
        check("peak_count", int'(bus.peak_count), m_peak);
`endif
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int v, input bit val, input bit dec);
        bus.push_valid = 1'b1;
        bus.push_var = VB'(v);
        bus.push_val = val;
        bus.push_decision = dec;
        tick;
        bus.push_valid = 1'b0;
    endtask

    task automatic bt;
        bus.bt_start = 1'b1;
        tick;
        bus.bt_start = 1'b0;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic lit_pop(input int v, input int val, input int dec, input int done, input int unsat);
        tick;
        @(negedge clock);
        check("lit_pop_valid", int'(bus.pop_valid), 1);
        check("lit_pop_var", int'(bus.pop_var), v);
        check("lit_pop_val", int'(bus.pop_val), val);
        check("lit_pop_dec", int'(bus.pop_decision), dec);
        check("lit_bt_done", int'(bus.bt_done), done);
        check("lit_bt_unsat", int'(bus.bt_unsat), unsat);
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_var = '0;
        bus.push_val = 1'b0;
        bus.push_decision = 1'b0;
        bus.bt_start = 1'b0;
        tick;
        chk_on = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clock);
        check("rst_count", int'(bus.count), 0);
        check("rst_level", int'(bus.level), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_push_ready", int'(bus.push_ready), 1);
        check("rst_pop_valid", int'(bus.pop_valid), 0);
        check("rst_bt_done", int'(bus.bt_done), 0);
        check("rst_bt_unsat", int'(bus.bt_unsat), 0);

        // Three entries, the bottom one a decision: all three come back.
        push(5, 1, 1); push(7, 0, 0); push(9, 1, 0);
        bt;
        @(negedge clock);
        check("t1_first_cycle_pop_valid", int'(bus.pop_valid), 0);
        check("t1_first_cycle_count", int'(bus.count), 3);
        check("t1_first_cycle_level", int'(bus.level), 1);
        lit_pop(9, 1, 0, 0, 0);
        lit_pop(7, 0, 0, 0, 0);
        lit_pop(5, 1, 1, 1, 0);
        check("t1_count", int'(bus.count), 0);
        check("t1_level", int'(bus.level), 0);
        tick;
        @(negedge clock);
        check("t1_push_ready_back", int'(bus.push_ready), 1);
        check("t1_pop_valid_idle", int'(bus.pop_valid), 0);

        // No decision on the stack: drains and reports unsat.
        push(3, 0, 0); push(4, 1, 0);
        bt;
        lit_pop(4, 1, 0, 0, 0);
        lit_pop(3, 0, 0, 1, 1);
        check("t2_empty", int'(bus.empty), 1);
        tick;
        @(negedge clock);
        check("t2_unsat_held", int'(bus.bt_unsat), 1);

        // Backtrack on an empty stack.
        bt;
        @(negedge clock);
        check("t3_done_t1", int'(bus.bt_done), 0);
        tick;
        @(negedge clock);
        check("t3_done_t2", int'(bus.bt_done), 1);
        check("t3_unsat_t2", int'(bus.bt_unsat), 1);
        check("t3_pop_valid_t2", int'(bus.pop_valid), 0);
        tick;

        // Push and bt_start together: backtrack wins, push is dropped.
        push(1, 0, 1);
        bus.push_valid = 1'b1; bus.push_var = VB'(2); bus.bt_start = 1'b1;
        tick;
        bus.push_valid = 1'b0; bus.bt_start = 1'b0;
        @(negedge clock);
        check("col_count", int'(bus.count), 1);
        lit_pop(1, 0, 1, 1, 0);
        tick;

        for (int n = 0; n < 4000; n++) begin
            bus.push_valid = $urandom_range(0, 3) != 0;
            bus.push_var = VB'($urandom);
            bus.push_val = 1'($urandom);
            bus.push_decision = $urandom_range(0, 3) == 0;
            bus.bt_start = $urandom_range(0, 24) == 0;
            reset = $urandom_range(0, 599) == 0;
            tick;
        end
        bus.push_valid = 1'b0; bus.bt_start = 1'b0;
        pulse_reset;

        for (int i = 0; i < DEPTH; i++) push(i, 1'(i), 1'(i % 7 == 0));
        @(negedge clock);
        check("fill_full", int'(bus.full), 1);
        check("fill_count", int'(bus.count), DEPTH);
        check("fill_push_ready", int'(bus.push_ready), 0);
        push(77, 1, 1);
        @(negedge clock);
        check("ovf_flag", int'(bus.overflow), 1);
        check("ovf_count", int'(bus.count), DEPTH);
`ifdef IMPLY_STACK_PEAK_EN
        check("ovf_peak", int'(bus.peak_count), DEPTH);
`endif

        // Reset while two of four pops have been delivered.
        pulse_reset;
        push(10, 0, 0); push(11, 1, 0); push(12, 0, 0); push(13, 1, 0);
        bt;
        tick; tick;
        @(negedge clock);
        check("mid_pop_var", int'(bus.pop_var), 12);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clock);
        check("mid_count", int'(bus.count), 0);
        check("mid_pop_valid", int'(bus.pop_valid), 0);
        check("mid_bt_busy", int'(bus.bt_busy), 0);
`ifdef IMPLY_STACK_PEAK_EN
        check("mid_peak", int'(bus.peak_count), 0);
`endif
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imply_stack.md
Name: imply_stack

Overview:
- LIFO trail of variable assignments for the SAT solver datapath. Sits directly downstream of the conflict detector.
- Each non-conflicting implication or decision is pushed as a (var, val, decision-flag) entry.
- On a solver backtrack request, entries are popped one per cycle, down to and including the most recent decision entry. Each popped entry is streamed out so the detector and assignment memory can clear that variable.
- Reports a done pulse, plus an UNSAT flag when no decision remains.

Parameters:
- VAR_BITS, 9, width of variable index.
- DEPTH, 512, maximum stack entries (one per variable).
- CNT_BITS, 10, width of count/level outputs; must hold DEPTH.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  entry offered this cycle.
- push_var  in  VAR_BITS  variable index.
- push_val  in  1  assigned value.
- push_decision  in  1  1 = decision (opens new level), 0 = implication.
- push_ready  out  1  combinational: state==IDLE && !full && !bt_start.
- bt_start  in  1  request backtrack; sampled only in IDLE.
- pop_valid  out  1  registered; one popped entry presented this cycle.
- pop_var  out  VAR_BITS  registered popped variable.
- pop_val  out  1  registered popped value.
- pop_decision  out  1  registered popped decision flag.
- bt_busy  out  1  high while state is POP or DONE.
- bt_done  out  1  high for the single cycle state==DONE.
- bt_unsat  out  1  valid with bt_done; 1 = stack emptied without finding a decision.
- count  out  CNT_BITS  current number of entries.
- level  out  CNT_BITS  number of decision entries on stack.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky; push_valid seen while full in IDLE.

Behaviour:
- Reset: state=IDLE; count, level, pop_*, bt_done, bt_unsat, overflow all 0.
  - Storage contents are don't-care.
  - Reset in any state, including mid-backtrack, aborts immediately.
- FSM states: IDLE, POP, DONE.
- IDLE:
  - bt_start has priority over push in the same cycle. On bt_start, go to POP; push is not accepted.
  - Otherwise push_valid && push_ready writes entry at index count. count+1 is visible the next cycle.
  - If the pushed entry has push_decision=1, level+1 as well.
  - push_valid && full: entry dropped, overflow<=1, count unchanged.
- POP, each clock edge:
  - If empty: go to DONE, bt_unsat<=1, no pop_valid.
  - Else: remove top entry, drive it on pop_* with pop_valid<=1, count-1.
    - If the entry's decision flag is set: level-1, go to DONE, bt_unsat<=0.
    - Else if this pop leaves the stack empty: go to DONE, bt_unsat<=1.
    - Else stay in POP.
- DONE: bt_done=1 for one cycle, then IDLE. bt_unsat holds until the next bt_start.
- pop_valid is a one-cycle-per-entry registered pulse. It is deasserted in IDLE.
- Timing (bt_start high in cycle t, k entries popped):
  - pop_valid high in cycles t+2..t+k+1.
  - bt_done in cycle t+k+1, coincident with the last pop_valid.
  - push_ready returns in cycle t+k+2.
- Timing, empty stack: bt_start in cycle t gives bt_done=1, bt_unsat=1 in cycle t+2, with no pop_valid.
- Pushes during POP/DONE are ignored: push_ready=0, overflow is not set.
- Arithmetic: count and level never wrap. Pop is guarded by empty; push is guarded by full.

Optional Feature:
- Macro IMPLY_STACK_PEAK_EN.
  - Defined: adds output peak_count (CNT_BITS). Reset to 0; updated to count+1 on any accepted push that exceeds it. Never decreases except on reset.
  - Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle: count=0, level=0, empty=1, full=0, push_ready=1, all pop_*/bt_* = 0.
- Push (5,1,dec=1), (7,0,0), (9,1,0), then bt_start. Required response:
  - pop_valid for 3 cycles with (9,1,0), (7,0,0), (5,1,1).
  - bt_done with bt_unsat=0 in the last of those cycles.
  - count=0, level=0.
- Push (3,0,0), (4,1,0) (no decision), then bt_start:
  - Pops (4,1,0) then (3,0,0).
  - bt_done with bt_unsat=1; empty=1.
- bt_start on empty stack at cycle t: bt_done=1 and bt_unsat=1 at t+2, pop_valid never asserted.
- Overflow and collision:
  - Fill to DEPTH=512: full=1, push_ready=0.
  - Extra push_valid: overflow=1, count stays 512.
  - push_valid and bt_start in the same IDLE cycle: push not stored, backtrack proceeds.
- Reset mid-backtrack: assert reset after 2 of 4 pops. Next cycle: state IDLE, count=0, pop_valid=0, bt_busy=0; with IMPLY_STACK_PEAK_EN, peak_count=0.
